// File: rtl/sid_bus_writer.sv
// SID bus master: generates phi2 and the power-on SID reset, and turns queued
// register-write requests into chip-select framed cycles aligned to phi2 falls.
module sid_bus_writer #(
   parameter int CLK_DIV    = 8,
   parameter int RES_CYCLES = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       C6_CLK_8MHZ,
   input  logic       C6_RESET,
   input  logic       WR_VALID,
   output logic       WR_READY,
   input  logic [4:0] WR_ADDR,
   input  logic [7:0] WR_DATA,
   output logic       BUSY,
   output logic       SID_CLK,
   output logic       SID_RES,
   output logic       SID_CS,
   output logic [4:0] SID_ADDR,
   output logic [7:0] SID_DATA
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RES_W = $clog2(RES_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [RES_W-1:0] RES_LAST = RES_W'(RES_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {RES_HOLD, IDLE, SETUP, HOLD} state_t;

   state_t           state_reg;
   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic [RES_W-1:0] res_cnt_reg;
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [12:0]      fifo_mem [FIFO_DEPTH];
   logic [12:0]      head;
   logic             tick_fall, full, empty, push, pop;

   assign tick_fall    = (div_cnt_reg == DIV_LAST);
   assign div_cnt_next = tick_fall ? '0 : div_cnt_reg + DIV_W'(1);

   assign full     = (count_reg == CNT_FULL);
   assign empty    = (count_reg == '0);
   assign WR_READY = !C6_RESET && !full;
   assign push     = WR_VALID && WR_READY;
   assign pop      = (state_reg == IDLE) && tick_fall && !empty;
   assign head     = fifo_mem[rd_ptr_reg];
   assign BUSY     = (state_reg != IDLE) || !empty;

   // Storage needs no reset: occupancy and pointers alone define validity.
   always_ff @(posedge C6_CLK_8MHZ) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= {WR_ADDR, WR_DATA};
   end

   always_ff @(posedge C6_CLK_8MHZ or posedge C6_RESET) begin
      if (C6_RESET) begin
         div_cnt_reg <= '0;
         SID_CLK     <= 1'b0;
         SID_RES     <= 1'b0;
         SID_CS      <= 1'b1;
         SID_ADDR    <= '0;
         SID_DATA    <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         res_cnt_reg <= '0;
         state_reg   <= RES_HOLD;
      end else begin
         div_cnt_reg <= div_cnt_next;
         SID_CLK     <= (div_cnt_next >= DIV_HALF);

         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)
            count_reg <= count_reg + CNT_W'(1);
         else if (pop && !push)
            count_reg <= count_reg - CNT_W'(1);

         case (state_reg)
            RES_HOLD: begin
               if (tick_fall) begin
                  if (res_cnt_reg == RES_LAST) begin
                     SID_RES   <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     res_cnt_reg <= res_cnt_reg + RES_W'(1);
                  end
               end
            end
            IDLE: begin
               if (pop) begin
                  SID_ADDR  <= head[12:8];
                  SID_DATA  <= head[7:0];
                  SID_CS    <= 1'b0;
                  state_reg <= SETUP;
               end
            end
            // The SID samples the bus on this phi2 fall; hold one more clock.
            SETUP: begin
               if (tick_fall)
                  state_reg <= HOLD;
            end
            HOLD: begin
               SID_CS    <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sid_bus_writer.sv
// Bench for sid_bus_writer: reset-timing vector table, hand-written bus cycle
// sequences, and random requests checked every cycle against an edge-count model.
module tb_sid_bus_writer;
   localparam int CLK_DIV    = 8;
   localparam int RES_CYCLES = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int HOLD_N     = CLK_DIV * RES_CYCLES;
   localparam int LIM        = 3000;

   logic       clk = 1'b0;
   logic       c6_reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       wr_ready, busy, sid_clk, sid_res, sid_cs;
   logic [4:0] sid_addr;
   logic [7:0] sid_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rel_cyc  = 0;

   sid_bus_writer #(
      .CLK_DIV(CLK_DIV), .RES_CYCLES(RES_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .C6_CLK_8MHZ(clk), .C6_RESET(c6_reset),
      .WR_VALID(wr_valid), .WR_READY(wr_ready),
      .WR_ADDR(wr_addr), .WR_DATA(wr_data), .BUSY(busy),
      .SID_CLK(sid_clk), .SID_RES(sid_res), .SID_CS(sid_cs),
      .SID_ADDR(sid_addr), .SID_DATA(sid_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: after edge n since reset release, everything follows from n,
   // the edge s of the last pop, and a queue of pending requests.
   int         m_n, m_s, nxt;
   logic [4:0] m_addr;
   logic [7:0] m_data;
   logic [12:0] m_q[$];
   bit         do_pop, do_push, exp_cs_low;

   initial begin
      forever begin
         @(negedge clk);
         if (c6_reset) begin
            m_n = 0; m_s = -1000; m_addr = '0; m_data = '0; m_q.delete();
            chk("rst_cs", sid_cs, 1);
            chk("rst_res", sid_res, 0);
            chk("rst_clk", sid_clk, 0);
            chk("rst_ready", wr_ready, 0);
            chk("rst_busy", busy, 1);
            chk("rst_addr", sid_addr, 0);
            chk("rst_data", sid_data, 0);
         end else begin
            exp_cs_low = (m_n >= m_s) && (m_n <= m_s + CLK_DIV);
            chk("m_clk", sid_clk, int'((m_n % CLK_DIV) >= CLK_DIV / 2));
            chk("m_res", sid_res, int'(m_n >= HOLD_N));
            chk("m_cs", sid_cs, int'(!exp_cs_low));
            chk("m_addr", sid_addr, m_addr);
            chk("m_data", sid_data, m_data);
            chk("m_busy", busy, int'((m_n < HOLD_N) || exp_cs_low || (m_q.size() > 0)));
            chk("m_ready", wr_ready, int'(m_q.size() < FIFO_DEPTH));
            nxt     = m_n + 1;
            do_pop  = (nxt % CLK_DIV == 0) && (nxt > HOLD_N) &&
                      (nxt >= m_s + CLK_DIV + 2) && (m_q.size() > 0);
            do_push = wr_valid && (m_q.size() < FIFO_DEPTH);
            if (do_pop) begin
               {m_addr, m_data} = m_q.pop_front();
               m_s = nxt;
               $display("model bus write addr=%02h data=%02h edge=%0d", m_addr, m_data, nxt);
            end
            if (do_push)
               m_q.push_back({wr_addr, wr_data});
            m_n = nxt;
         end
      end
   end

   // Caller is at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic push_req(input logic [4:0] a, input logic [7:0] d);
      int g = 0;
      bit done = 0;
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      while (!done) begin
         @(negedge clk);
         done = wr_ready || (g >= LIM);
         g++;
         @(posedge clk); #2;
      end
      chk("push_timeout", int'(g > LIM), 0);
      $display("push addr=%02h data=%02h", a, d);
   endtask

   task automatic measure_write(input logic [4:0] ea, input logic [7:0] ed, output int start);
      int g = 0;
      int len = 0;
      int falls = 0;
      logic prev;
      @(negedge clk);
      prev = sid_clk;
      while (sid_cs && g < LIM) begin
         prev = sid_clk;
         @(negedge clk);
         g++;
      end
      chk("cs_start_timeout", int'(g >= LIM), 0);
      start = cyc;
      chk("cs_start_on_fall", int'({prev, sid_clk}), 2);
      chk("cs_start_res", sid_res, 1);
      while (!sid_cs && len < LIM) begin
         len++;
         chk("win_addr", sid_addr, ea);
         chk("win_data", sid_data, ed);
         prev = sid_clk;
         @(negedge clk);
         if (prev && !sid_clk && !sid_cs)
            falls++;
      end
      chk("cs_low_len", len, CLK_DIV + 1);
      chk("cs_win_falls", falls, 1);
      $display("bus write addr=%02h data=%02h start=%0d cs_low=%0d", ea, ed, start - rel_cyc, len);
   endtask

   typedef struct {
      int   n;
      logic res;
      logic phi;
      logic cs;
      logic bsy;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int st, g, cs_low_cnt;
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int g;
      int cs_low_cnt;
      vecs[0] = '{0,   1'b0, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{3,   1'b0, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{4,   1'b0, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{7,   1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{8,   1'b0, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{127, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[6] = '{128, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{136, 1'b1, 1'b0, 1'b1, 1'b0};

      // Power-on hold and phi2 waveform against the vector table.
      repeat (3) @(posedge clk);
      #2 c6_reset = 1'b0;
      rel_cyc = cyc;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         while (cyc - rel_cyc < vecs[i].n) @(negedge clk);
         chk($sformatf("vec%0d_res", i), sid_res, vecs[i].res);
         chk($sformatf("vec%0d_clk", i), sid_clk, vecs[i].phi);
         chk($sformatf("vec%0d_cs", i), sid_cs, vecs[i].cs);
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
         $display("vector n=%0d res=%0b clk=%0b cs=%0b busy=%0b", vecs[i].n, sid_res, sid_clk, sid_cs, busy);
      end

      // Single write.
      @(posedge clk); #2;
      push_req(5'h18, 8'h0F);
      wr_valid = 1'b0;
      measure_write(5'h18, 8'h0F, st);
      chk("t2_busy_after", busy, 0);

      // Six requests with WR_VALID held; bus order and spacing.
      @(posedge clk); #2;
      fork
         begin
            for (int i = 0; i < 6; i++) push_req(5'(i), 8'hA0 + 8'(i));
            wr_valid = 1'b0;
         end
         begin
            int prev_st;
            int cur_st;
            prev_st = 0;
            for (int i = 0; i < 6; i++) begin
               measure_write(5'(i), 8'hA0 + 8'(i), cur_st);
               if (i > 0) chk("t3_spacing", cur_st - prev_st, 2 * CLK_DIV);
               prev_st = cur_st;
            end
         end
      join

      // Random traffic keeps the FIFO full while pops occur.
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #2;
         wr_valid = ($urandom_range(0, 1) == 1);
         wr_addr  = 5'($urandom);
         wr_data  = 8'($urandom);
      end
      @(posedge clk); #2;
      wr_valid = 1'b0;
      g = 0;
      @(negedge clk);
      while (busy && g < LIM) begin
         @(negedge clk);
         g++;
      end
      chk("drain_timeout", int'(g >= LIM), 0);

      // Writes queued during the reset hold.
      @(posedge clk); #2;
      c6_reset = 1'b1;
      repeat (3) @(posedge clk);
      #2 c6_reset = 1'b0;
      rel_cyc = cyc;
      push_req(5'h11, 8'h22);
      push_req(5'h12, 8'h33);
      wr_valid = 1'b0;
      measure_write(5'h11, 8'h22, st);
      chk("t4_first_start", st - rel_cyc, HOLD_N + CLK_DIV);
      measure_write(5'h12, 8'h33, st);
      chk("t4_second_start", st - rel_cyc, HOLD_N + 3 * CLK_DIV);

      // Reset arriving during SETUP aborts the write.
      @(posedge clk); #2;
      push_req(5'h1F, 8'hEE);
      wr_valid = 1'b0;
      g = 0;
      @(negedge clk);
      while (sid_cs && g < LIM) begin
         @(negedge clk);
         g++;
      end
      chk("t5_cs_timeout", int'(g >= LIM), 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      chk("t5_cs_before", sid_cs, 0);
      c6_reset = 1'b1;
      #1;
      chk("t5_cs_async", sid_cs, 1);
      chk("t5_res_async", sid_res, 0);
      chk("t5_ready_rst", wr_ready, 0);
      chk("t5_busy_rst", busy, 1);
      repeat (2) @(posedge clk);
      #2 c6_reset = 1'b0;
      rel_cyc = cyc;
      cs_low_cnt = 0;
      for (int k = 0; k < HOLD_N + 6 * CLK_DIV; k++) begin
         @(negedge clk);
         if (!sid_cs) cs_low_cnt++;
      end
      chk("t5_no_reissue", cs_low_cnt, 0);
      chk("t5_busy_end", busy, 0);
      chk("t5_ready_end", wr_ready, 1);
      chk("t5_res_end", sid_res, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sid_bus_writer.md
Name: sid_bus_writer

Overview:
- Turns queued SID register-write requests into correctly timed SID bus cycles.
- Generates the SID phi2 clock (SID_CLK) from the 8 MHz board clock, the power-on SID reset pulse, and active-low chip select around each write.
- Sits between the CPU/sequencer write path and the SID pins, replacing the static pin-driving test module.
- Write-only: the SID R/W pin is tied low at board level.

Parameters:
- CLK_DIV, 8: system clocks per SID_CLK period. Even, at least 4. Default gives 1 MHz.
- RES_CYCLES, 16: SID_CLK periods that SID_RES is held low after reset release.
- FIFO_DEPTH, 4: write-request FIFO entries. Power of 2, at least 2.

Ports:
- C6_CLK_8MHZ  in  1  system clock. All logic runs on its rising edge.
- C6_RESET  in  1  asynchronous, active-high reset.
- WR_VALID  in  1  write request valid.
- WR_READY  out  1  FIFO can accept a request.
- WR_ADDR  in  5  SID register address.
- WR_DATA  in  8  SID register data.
- BUSY  out  1  reset hold in progress, FIFO non-empty, or write in flight.
- SID_CLK  out  1  SID phi2 clock.
- SID_RES  out  1  SID reset, active low.
- SID_CS  out  1  SID chip select, active low.
- SID_ADDR  out  5  SID address pins.
- SID_DATA  out  8  SID data pins.

Behaviour:
- Reset (async, immediate while C6_RESET=1):
  - div_cnt=0, SID_CLK=0, SID_RES=0, SID_CS=1, SID_ADDR=0, SID_DATA=0.
  - FIFO flushed, WR_READY=0, BUSY=1, state=RES_HOLD.
  - A reset that arrives mid-write aborts it; CS goes high asynchronously.
- Phi2 generator:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - SID_CLK is a registered output, 1 when the next div_cnt is at least CLK_DIV/2. High phase is the second half of each period; duty cycle is 50%.
  - tick_fall = (div_cnt==CLK_DIV-1). On this edge div_cnt wraps to 0 and SID_CLK falls.
- FIFO:
  - WR_READY = !full outside reset. WR_READY=1 during RES_HOLD once C6_RESET is low.
  - Push on WR_VALID & WR_READY. Pop happens only in IDLE on tick_fall when the FIFO is non-empty.
  - No bypass: when full, a push is refused even on the cycle a pop occurs.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- States:
  - RES_HOLD: SID_RES=0. Counts RES_CYCLES tick_falls. On the last one, SID_RES goes to 1 and state goes to IDLE. No pop occurs on that same tick.
  - IDLE: on tick_fall with FIFO non-empty, pop the head. On the same edge, register SID_ADDR/SID_DATA from the head and set SID_CS=0. Go to SETUP.
  - SETUP: CS, address and data stay stable through the phi2 low and high phases. On the next tick_fall (SID latches on this falling edge), go to HOLD. CS stays 0.
  - HOLD: one system clock of hold time. Then SID_CS=1 and state goes to IDLE.
- Timing per write:
  - CS is low for exactly CLK_DIV+1 clocks.
  - Exactly one SID_CLK falling edge occurs while CS is low, with address and data stable.
  - Maximum throughput is one write per 2 phi2 periods.
- Output holding: SID_ADDR/SID_DATA hold their last written values between writes. WR_ADDR passes through unchecked; all 5-bit values are allowed.
- BUSY = (state!=IDLE) | !empty.

Test Plan:
1. Release reset with defaults → SID_RES low for exactly 128 clocks after deassertion; SID_CLK period 8 clocks, 4 high / 4 low; SID_CS=1 throughout; BUSY=1 until hold ends.
2. After the hold, single write addr=0x18 data=0x0F → SID_CS low for exactly 9 clocks starting at a SID_CLK falling edge; one SID_CLK falling edge occurs inside the window with SID_ADDR=0x18, SID_DATA=0x0F stable; BUSY drops the cycle CS returns high.
3. WR_VALID held with 6 requests (addrs 0x00..0x05) in IDLE → first 4 accepted back-to-back, then WR_READY=0 until the first pop; bus shows 0x00..0x05 in order; successive CS-low starts are 16 clocks apart.
4. Two writes pushed during RES_HOLD → both accepted; no CS activity before SID_RES=1; first CS low at the first tick_fall after the one that released SID_RES.
5. Assert C6_RESET during SETUP → SID_CS=1 and SID_RES=0 before the next clock edge; FIFO empty afterwards; the aborted write is never re-issued after the new hold.
6. FIFO full and a pop occurring with WR_VALID=1 → push refused that cycle, accepted the following cycle; no entry lost or duplicated.
